clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Parametrised multi-channel clock divider. Generates NCH divided clock-like square waves
//  (div_clk) plus single-cycle clock-enable strobes (tick) from one fabric clock.
//  Divide ratios are runtime-programmable, with glitch-free update at period boundaries.
//  Consumers gate logic with tick on clk; div_clk is a registered level for pins/debug only.
// PARAMETERS
//  NCH      4   number of independent divider channels (>=1)
//  CNT_W    16  width of ratio and counter per channel
//  DEF_DIV  4   active ratio loaded into every channel at reset (>=1, < 2**CNT_W)
// PORTS
//  clk         in   1            fabric clock, all logic on posedge
//  reset_n     in   1            asynchronous, active-low reset
//  en          in   NCH          per-channel run enable
//  load        in   NCH          1-cycle strobe: capture div_ratio[i] into shadow of channel i
//  div_ratio   in   NCH*CNT_W    requested ratio per channel (packed [NCH-1:0][CNT_W-1:0])
//  sync        in   1            1-cycle strobe: realign all enabled channels to phase 0
//  div_clk     out  NCH          divided square wave per channel, registered
//  tick        out  NCH          1-cycle pulse at start of each divided period, registered
//  pending     out  NCH          shadow ratio captured, not yet active
// BEHAVIOUR
//  Reset (reset_n=0, async): cnt=0, active ratio N=DEF_DIV, shadow=DEF_DIV, div_clk=0, tick=0,
//   pending=0. Outputs remain low until en sampled high after reset release.
//  Effective ratio: N=0 treated as N=1. Ratio arithmetic unsigned, CNT_W bits, no wrap beyond N-1.
//  Run (en[i]=1): cnt counts 0..N-1 then wraps to 0. Outputs registered from next cnt:
//   tick=1 exactly when cnt==0; div_clk=1 for cnt < ceil(N/2), 0 otherwise.
//   => tick period N cycles; div_clk high ceil(N/2), low floor(N/2); N=1: tick and div_clk held 1.
//  Start latency: first posedge sampling en=1 on a disabled channel sets cnt=0, tick=1, div_clk=1.
//  Disable (en[i]=0): next posedge cnt=0, tick=0, div_clk=0; no partial period completes.
//  Load: load[i] -> shadow<=div_ratio[i], pending[i]=1 next cycle. Active ratio unchanged
//   mid-period. Shadow becomes active on wrap edge (cnt==N-1 -> 0); pending clears same edge.
//   Channel disabled: shadow applied on the load edge itself, pending stays 0.
//   Load while pending: newer value overwrites shadow; only last value is applied.
//   Load on the wrap edge: new value captured but applied at the following wrap (pending=1).
//  Sync: all enabled channels cnt<=0 next edge (tick=1, div_clk=1), pending shadows applied
//   on that edge. Disabled channels ignore sync. sync with load same cycle: new value captured
//   as pending, applied on next wrap (load has lower priority than sync application).
//  Priority per channel per edge: reset_n > en=0 > sync > wrap > count.
//  Reset mid-period: all state returns to reset values immediately; no glitch beyond async clear.
//  No combinational path from inputs to outputs; div_clk never used as a clock inside block.
// STRUCTURE
//  Package clk_div_pkg: typedef logic [CNT_W-1:0] ratio_t (with CNT_W localparam default 16),
//   constant DEF_DIV_C, function half_up(ratio_t) returning ceil(N/2).
//  Sub-module clk_div_chan: one channel (cnt, active, shadow, pending, output regs);
//   top-level generates NCH instances and fans out clk, reset_n, sync.
// TESTING
//  T1 reset: reset_n=0 mid-run with N=6 -> div_clk=0,tick=0,pending=0 asynchronously; after release,
//     en=1 -> tick period 4 (DEF_DIV), div_clk 2 high/2 low.
//  T2 odd ratio: load 5, en=1 -> tick every 5 cycles; div_clk 3 high, 2 low; N=1 -> both held 1.
//  T3 update at boundary: running N=8, load 3 at cnt=2 -> pending=1, current period finishes
//     8 cycles, then period 3; pending clears on the wrap edge.
//  T4 back-to-back loads: load 10 then load 6 within one period -> only 6 applied, never 10.
//  T5 sync: ch0 N=4, ch1 N=6 out of phase; pulse sync -> both tick next cycle, coincide every 12.
//  T6 enable gating: drop en[2] mid-period -> outputs 0 next cycle; reassert -> tick first cycle,
//     other channels unaffected throughout; N=0 behaves as N=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, default ratio and helpers for the multi-channel clock divider
package clk_div_pkg;
    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] ratio_t;
    localparam ratio_t DEF_DIV_C = ratio_t'(4);
    function automatic ratio_t half_up(ratio_t n);
        return (n >> 1) + ratio_t'(n[0]);
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed ratio applied at period boundaries
//  clk        in   fabric clock
//  reset_n    in   asynchronous active-low reset
//  en         in   run enable
//  load       in   strobe: capture div_ratio into shadow
//  div_ratio  in   requested ratio (0 behaves as 1)
//  sync       in   strobe: restart period at phase 0
//  div_clk    out  registered square wave, high for ceil(N/2) of N cycles
//  tick       out  registered pulse on the first cycle of each period
//  pending    out  shadow captured but not yet active
module clk_div_chan #(
    parameter int CNT_W   = clk_div_pkg::CNT_W,
    parameter int DEF_DIV = int'(clk_div_pkg::DEF_DIV_C)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             sync,
    output logic             div_clk,
    output logic             tick,
    output logic             pending
);
    logic [CNT_W-1:0] cnt, active, shadow, eff, half, cnt_nxt, active_nxt, shadow_nxt;
    logic             run, pending_nxt, bound;
    always_comb begin
        eff         = (active == '0) ? CNT_W'(1) : active;
        half        = (eff >> 1) + CNT_W'(eff[0]);
        // a sync realigns exactly like a natural wrap, including shadow hand-over
        bound       = sync || (run && cnt == eff - CNT_W'(1));
        cnt_nxt     = (bound || !run) ? '0 : cnt + CNT_W'(1);
        active_nxt  = (pending && bound) ? shadow : active;
        shadow_nxt  = load ? div_ratio : shadow;
        pending_nxt = load || (pending && !bound);
        // a stopped channel has no period to protect, so ratio changes take effect at once
        if (!en) begin
            cnt_nxt     = '0;
            active_nxt  = shadow_nxt;
            pending_nxt = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            active  <= CNT_W'(DEF_DIV);
            shadow  <= CNT_W'(DEF_DIV);
            pending <= 1'b0;
            run     <= 1'b0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            active  <= active_nxt;
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
            run     <= en;
            tick    <= en && cnt_nxt == '0;
            div_clk <= en && cnt_nxt < half;
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable clock dividers sharing clk, reset_n and sync
//  clk        in   fabric clock
//  reset_n    in   asynchronous active-low reset
//  en         in   [NCH] per-channel run enable
//  load       in   [NCH] per-channel shadow capture strobe
//  div_ratio  in   [NCH][CNT_W] requested ratio per channel
//  sync       in   strobe: realign all enabled channels to phase 0
//  div_clk    out  [NCH] divided square waves (pins/debug only, never a clock)
//  tick       out  [NCH] clock-enable strobes, one per divided period
//  pending    out  [NCH] shadow ratio waiting for the next boundary
module clk_div_multi #(
    parameter int NCH     = 4,
    parameter int CNT_W   = clk_div_pkg::CNT_W,
    parameter int DEF_DIV = int'(clk_div_pkg::DEF_DIV_C)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCH-1:0]            en,
    input  logic [NCH-1:0]            load,
    input  logic [NCH-1:0][CNT_W-1:0] div_ratio,
    input  logic                      sync,
    output logic [NCH-1:0]            div_clk,
    output logic [NCH-1:0]            tick,
    output logic [NCH-1:0]            pending
);
    import clk_div_pkg::*;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en[i]),
            .load     (load[i]),
            .div_ratio(div_ratio[i]),
            .sync     (sync),
            .div_clk  (div_clk[i]),
            .tick     (tick[i]),
            .pending  (pending[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench; expected tick cycles are queued, a monitor pops them on each tick
module tb_clk_div_multi;
    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       en, load, div_clk, tick, pending;
    logic [3:0][15:0] div_ratio;
    logic             sync;
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;
    int unsigned      exp_q [4][$];

    clk_div_multi #(.NCH(4), .CNT_W(16), .DEF_DIV(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load     (load),
        .div_ratio(div_ratio),
        .sync     (sync),
        .div_clk  (div_clk),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (tick[ch]) begin
                total++;
                if (exp_q[ch].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tick ch%0d: tick at cycle %0d, none expected", ch, cyc);
                end else begin
                    int unsigned e;
                    e = exp_q[ch].pop_front();
                    if (e != cyc) begin
                        bad++;
                        $display("FAIL tick_time ch%0d: got cycle %0d, want cycle %0d", ch, cyc, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int ch, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s ch%0d: got %0d, want %0d", nm, ch, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        load = '0;
        sync = 1'b0;
    endtask

    task automatic push_ticks(input int ch, input int first, input int per, input int last);
        for (int t = first; t <= last; t += per) exp_q[ch].push_back(t);
    endtask

    task automatic preload(input int ch, input int v);
        div_ratio[ch] = 16'(v);
        load[ch] = 1'b1;
        step();
        chk("preload_pending", ch, int'(pending[ch]), 0);
    endtask

    task automatic run_seq(input int ch, input string dc, input string tk, input string pd,
                           input int lk1, input int lv1, input int lk2, input int lv2);
        int c0;
        c0 = cyc;
        for (int i = 0; i < tk.len(); i++) if (tk[i] == "1") exp_q[ch].push_back(c0 + 1 + i);
        en[ch] = 1'b1;
        for (int k = 1; k <= dc.len(); k++) begin
            step();
            chk("div_clk", ch, int'(div_clk[ch]), int'(dc[k-1] == "1"));
            chk("pending", ch, int'(pending[ch]), int'(pd[k-1] == "1"));
            if (k == lk1) begin load[ch] = 1'b1; div_ratio[ch] = 16'(lv1); end
            if (k == lk2) begin load[ch] = 1'b1; div_ratio[ch] = 16'(lv2); end
        end
        en[ch] = 1'b0;
        step();
        chk("off_tick", ch, int'(tick[ch]), 0);
        chk("off_div_clk", ch, int'(div_clk[ch]), 0);
        chk("missing_ticks", ch, exp_q[ch].size(), 0);
    endtask

    initial begin
        int c;
        reset_n = 1'b0;
        en = '0;
        load = '0;
        sync = 1'b0;
        div_ratio = '0;
        step();
        step();
        chk("reset_div_clk", 0, int'(div_clk), 0);
        chk("reset_tick", 0, int'(tick), 0);
        chk("reset_pending", 0, int'(pending), 0);
        reset_n = 1'b1;
        step();

        // T1: async reset mid-period with a pending load, then default ratio 4
        preload(0, 6);
        c = cyc;
        push_ticks(0, c + 1, 6, c + 9);
        en[0] = 1'b1;
        repeat (8) step();
        div_ratio[0] = 16'd7;
        load[0] = 1'b1;
        step();
        chk("t1_pending", 0, int'(pending[0]), 1);
        chk("t1_div_clk", 0, int'(div_clk[0]), 1);
        #2 reset_n = 1'b0;
        en = '0;
        #1;
        chk("t1_async_div_clk", 0, int'(div_clk[0]), 0);
        chk("t1_async_tick", 0, int'(tick[0]), 0);
        chk("t1_async_pending", 0, int'(pending[0]), 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("t1_missing_ticks", 0, exp_q[0].size(), 0);
        run_seq(0, "11001100110", "10001000100", "00000000000", 0, 0, 0, 0);

        // T2: odd ratio, N=1 and N=0
        preload(0, 5);
        run_seq(0, "111001110011100", "100001000010000", "000000000000000", 0, 0, 0, 0);
        preload(0, 1);
        run_seq(0, "11111", "11111", "00000", 0, 0, 0, 0);
        preload(0, 0);
        run_seq(0, "11111", "11111", "00000", 0, 0, 0, 0);

        // T3: load 3 at cnt=2 of an 8-period
        preload(0, 8);
        run_seq(0, "111100001101101", "100000001001001", "000111110000000", 3, 3, 0, 0);

        // T4: load 10 then 6 in one period; only 6 is applied
        preload(0, 8);
        run_seq(0, "1111000011100011100011", "1000000010000010000010",
                "0011111100000000000000", 2, 10, 4, 6);

        // T5: sync aligns ch0 (N=4) and ch1 (N=6)
        preload(0, 4);
        preload(1, 6);
        c = cyc;
        push_ticks(0, c + 1, 4, c + 5);
        push_ticks(1, c + 2, 6, c + 2);
        push_ticks(0, c + 7, 4, c + 19);
        push_ticks(1, c + 7, 6, c + 19);
        en[0] = 1'b1;
        step();
        en[1] = 1'b1;
        repeat (5) step();
        sync = 1'b1;
        step();
        chk("t5_sync_tick", 0, int'(tick[1:0]), 3);
        repeat (12) step();
        chk("t5_coincide", 0, int'(tick[1:0]), 3);
        step();
        en = '0;
        step();
        chk("t5_missing_ticks", 0, exp_q[0].size(), 0);
        chk("t5_missing_ticks", 1, exp_q[1].size(), 0);

        // T6: drop and reassert en[2] while ch0/ch1 keep running
        preload(0, 4);
        preload(1, 3);
        preload(2, 5);
        c = cyc;
        push_ticks(0, c + 1, 4, c + 22);
        push_ticks(1, c + 1, 3, c + 22);
        push_ticks(2, c + 1, 5, c + 6);
        push_ticks(2, c + 11, 5, c + 22);
        en[2:0] = 3'b111;
        repeat (8) step();
        chk("t6_div_clk_before", 2, int'(div_clk[2]), 1);
        en[2] = 1'b0;
        step();
        chk("t6_off_tick", 2, int'(tick[2]), 0);
        chk("t6_off_div_clk", 2, int'(div_clk[2]), 0);
        step();
        en[2] = 1'b1;
        step();
        chk("t6_restart_tick", 2, int'(tick[2]), 1);
        chk("t6_restart_div_clk", 2, int'(div_clk[2]), 1);
        repeat (11) step();
        en = '0;
        step();
        for (int ch = 0; ch < 3; ch++) chk("t6_missing_ticks", ch, exp_q[ch].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
